// File: rtl/vid_pkg.sv
// vid_pkg: shared state encoding, timing config layout and sync polarity constants for the pixel engine
package vid_pkg;
  localparam int CW_DEF = 13;
  localparam logic POL_HIGH = 1'b1;
  localparam logic POL_LOW = 1'b0;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FINISH} vid_state_e;
  typedef struct packed {
    logic [CW_DEF-1:0] size, limit, sync_start, sync_end;
  } axis_cfg_t;
  typedef struct packed {
    axis_cfg_t h, v;
  } timing_cfg_t;
  function automatic logic drive_pol(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vid_axis_cnt.sv
// vid_axis_cnt: one scan axis (position counter with wrap, blank and sync decode)
// clk/reset: clock and sync active-high reset; advance: step the count
// limit: last index before wrap; size: displayed count; sync_start/sync_end: sync window [start,end)
// count: position; wrap: advancing past limit this cycle; blank: count>=size; sync: inside window
module vid_axis_cnt #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  input  logic [CW-1:0] limit,
  input  logic [CW-1:0] size,
  input  logic [CW-1:0] sync_start,
  input  logic [CW-1:0] sync_end,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          blank,
  output logic          sync
);
  always_comb begin
    wrap = advance && count == limit;
    blank = count >= size;
    sync = count >= sync_start && count < sync_end;
  end
  // Wrap by compare rather than overflow so an all-ones limit is safe.
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (advance) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vid_pixel_engine.sv
// vid_pixel_engine: video timing generator that pops pixels from a FIFO and drives sync, blank and rgb
// clk/reset: clock and sync active-high reset; en: run enable; pcnt: pixel period minus one
// hsize/hend/hsync_start/hsync_end, vsize/vend/vsync_start/vsync_end: timing, captured on start
// pix_valid/pix_data/pix_ready: upstream FIFO pop handshake
// hsync/hblank/vsync/vblank/rgb/frame_start: registered display outputs
// underflow/clr_underflow: sticky missed-pixel flag and its clear
module vid_pixel_engine
  import vid_pkg::*;
#(
  parameter int   CW     = CW_DEF,
  parameter int   NCH    = 3,
  parameter int   BPC    = 8,
  parameter int   PDW    = 6,
  parameter logic HS_POL = POL_HIGH,
  parameter logic VS_POL = POL_HIGH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PDW-1:0]     pcnt,
  input  logic [CW-1:0]      hsize,
  input  logic [CW-1:0]      hend,
  input  logic [CW-1:0]      hsync_start,
  input  logic [CW-1:0]      hsync_end,
  input  logic [CW-1:0]      vsize,
  input  logic [CW-1:0]      vend,
  input  logic [CW-1:0]      vsync_start,
  input  logic [CW-1:0]      vsync_end,
  input  logic               pix_valid,
  input  logic [NCH*BPC-1:0] pix_data,
  output logic               pix_ready,
  output logic               hsync,
  output logic               hblank,
  output logic               vsync,
  output logic               vblank,
  output logic [NCH*BPC-1:0] rgb,
  output logic               frame_start,
  output logic               underflow,
  input  logic               clr_underflow
);
  typedef struct packed {
    logic [CW-1:0] size, limit, sync_start, sync_end;
  } axis_t;
  vid_state_e state;
  axis_t hc, vc;
  logic [PDW-1:0] pcnt_s, dcnt;
  logic [CW-1:0] hcnt, vcnt;
  logic active, tick, go_idle;
  logic h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync;
  // Counters only move while active and leave active only on a full-frame wrap,
  // so they always sit at zero in IDLE/PRIME without an explicit clear.
  vid_axis_cnt #(.CW(CW)) u_h (
    .clk, .reset, .advance(tick), .limit(hc.limit), .size(hc.size),
    .sync_start(hc.sync_start), .sync_end(hc.sync_end),
    .count(hcnt), .wrap(h_wrap), .blank(h_blank), .sync(h_sync)
  );
  vid_axis_cnt #(.CW(CW)) u_v (
    .clk, .reset, .advance(tick && h_wrap), .limit(vc.limit), .size(vc.size),
    .sync_start(vc.sync_start), .sync_end(vc.sync_end),
    .count(vcnt), .wrap(v_wrap), .blank(v_blank), .sync(v_sync)
  );
  // Reset gates tick so nothing is popped in the reset cycle.
  always_comb begin
    active = state == RUN || state == FINISH;
    tick = active && !reset && dcnt == pcnt_s;
    pix_ready = tick && !h_blank && !v_blank;
    go_idle = state == FINISH && tick && v_wrap;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dcnt <= '0;
      pcnt_s <= '0;
      hc <= '0;
      vc <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      hblank <= 1'b1;
      vblank <= 1'b1;
      rgb <= '0;
      frame_start <= 1'b0;
      underflow <= 1'b0;
    end else begin
      dcnt <= (!active || tick) ? '0 : dcnt + 1'b1;
      frame_start <= tick && hcnt == '0 && vcnt == '0;
      underflow <= (pix_ready && !pix_valid) || (underflow && !clr_underflow);
      case (state)
        IDLE: if (en) begin
          state <= PRIME;
          pcnt_s <= pcnt;
          hc <= {hsize, hend, hsync_start, hsync_end};
          vc <= {vsize, vend, vsync_start, vsync_end};
        end
        PRIME: state <= !en ? IDLE : pix_valid ? RUN : PRIME;
        RUN: if (!en) state <= FINISH;
        FINISH: if (go_idle) state <= IDLE;
      endcase
      // Outputs go inactive as the engine drops to IDLE instead of holding the last tick.
      if (go_idle) begin
        hsync <= ~HS_POL;
        vsync <= ~VS_POL;
        hblank <= 1'b1;
        vblank <= 1'b1;
        rgb <= '0;
      end else if (tick) begin
        hsync <= drive_pol(h_sync, HS_POL);
        vsync <= drive_pol(v_sync, VS_POL);
        hblank <= h_blank;
        vblank <= v_blank;
        rgb <= (pix_ready && pix_valid) ? pix_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_vid_pixel_engine.sv
// tb_vid_pixel_engine: directed self-checking bench for vid_pixel_engine
module tb_vid_pixel_engine;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, pix_valid = 1'b0, clr_underflow = 1'b0;
  logic [5:0] pcnt = 6'd0;
  logic [12:0] hsize = 13'd4, hend = 13'd7, hsync_start = 13'd5, hsync_end = 13'd7;
  logic [12:0] vsize = 13'd2, vend = 13'd3, vsync_start = 13'd2, vsync_end = 13'd3;
  logic [23:0] pix_data = 24'h010203, rgb;
  logic pix_ready, hsync, hblank, vsync, vblank, frame_start, underflow;
  logic en2 = 1'b0, pix_valid2 = 1'b0;
  logic [39:0] pix_data2 = 40'h0, rgb2;
  logic pix_ready2, hsync2, hblank2, vsync2, vblank2, frame_start2, underflow2;
  int checks = 0, errors = 0;
  int word_idx = 0;
  logic s_rdy, s_valid;
  always #5 clk = ~clk;
  vid_pixel_engine dut (
    .clk(clk), .reset(reset), .en(en), .pcnt(pcnt),
    .hsize(hsize), .hend(hend), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vsize(vsize), .vend(vend), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank), .rgb(rgb),
    .frame_start(frame_start), .underflow(underflow), .clr_underflow(clr_underflow)
  );
  vid_pixel_engine #(.CW(16), .NCH(4), .BPC(10), .PDW(6), .HS_POL(1'b0), .VS_POL(1'b1)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .pcnt(6'd0),
    .hsize(16'd2), .hend(16'hFFFF), .hsync_start(16'hFFFE), .hsync_end(16'hFFFF),
    .vsize(16'd2), .vend(16'd1), .vsync_start(16'd0), .vsync_end(16'd0),
    .pix_valid(pix_valid2), .pix_data(pix_data2), .pix_ready(pix_ready2),
    .hsync(hsync2), .hblank(hblank2), .vsync(vsync2), .vblank(vblank2), .rgb(rgb2),
    .frame_start(frame_start2), .underflow(underflow2), .clr_underflow(1'b0)
  );
  // One clock: sample the pop strobe mid-cycle, then let the FIFO model advance after the edge.
  task automatic tick_cycle();
    @(negedge clk);
    s_rdy = pix_ready;
    s_valid = pix_valid;
    @(posedge clk);
    #1;
    if (s_rdy && s_valid) begin
      word_idx++;
      pix_data = 24'h010203 + 24'(word_idx);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    pix_valid = 1'b1;
    clr_underflow = 1'b0;
    word_idx = 0;
    pix_data = 24'h010203;
    tick_cycle();
    tick_cycle();
    reset = 1'b0;
    pcnt = 6'd0;
    hsize = 13'd4; hend = 13'd7; hsync_start = 13'd5; hsync_end = 13'd7;
    vsize = 13'd2; vend = 13'd3; vsync_start = 13'd2; vsync_end = 13'd3;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hsync, vsync, hblank, vblank, frame_start, underflow, pix_ready} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_flags: got hs/vs/hb/vb/fs/uf/rdy=%b expected 0011000", {hsync, vsync, hblank, vblank, frame_start, underflow, pix_ready});
    end
    checks++;
    if (rgb !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %h expected 000000", rgb);
    end
    checks++;
    if ({hsync2, vsync2, hblank2, vblank2, frame_start2, underflow2, pix_ready2} !== 7'b1011000) begin
      errors++;
      $display("FAIL reset_flags_wide: got hs/vs/hb/vb/fs/uf/rdy=%b expected 1011000", {hsync2, vsync2, hblank2, vblank2, frame_start2, underflow2, pix_ready2});
    end
    checks++;
    if (rgb2 !== 40'h0) begin
      errors++;
      $display("FAIL reset_rgb_wide: got %h expected 0", rgb2);
    end
  endtask
  // Geometry 8x4 with 4x2 display; tick every pc+1 cycles starting at edge pc+3.
  task automatic test_scan(input int pc, input int n_edges, input int exp_pops);
    int f, p, k, h, v, np, nfs, fs1, fs2, pops;
    logic tk, e_rdy, e_hs, e_vs, e_hb, e_vb, e_fs;
    logic [23:0] e_rgb;
    do_reset();
    pcnt = 6'(pc);
    en = 1'b1;
    f = pc + 3;
    p = pc + 1;
    np = 0; nfs = 0; fs1 = -1; fs2 = -1; pops = 0;
    e_hs = 1'b0; e_vs = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_rgb = 24'h0;
    for (int e = 1; e <= n_edges; e++) begin
      tick_cycle();
      tk = e >= f && (e - f) % p == 0;
      k = (e - f) / p;
      h = k % 8;
      v = (k / 8) % 4;
      e_rdy = tk && h < 4 && v < 2;
      e_fs = tk && h == 0 && v == 0;
      if (tk) begin
        e_hs = h == 5 || h == 6;
        e_vs = v == 2;
        e_hb = h >= 4;
        e_vb = v >= 2;
        e_rgb = e_rdy ? 24'h010203 + 24'(np) : 24'h0;
        if (e_rdy) np++;
      end
      if (s_rdy) pops++;
      if (frame_start) begin
        nfs++;
        if (nfs == 1) fs1 = e;
        else if (nfs == 2) fs2 = e;
      end
      checks++;
      if ({s_rdy, hsync, vsync, hblank, vblank, frame_start, rgb} !== {e_rdy, e_hs, e_vs, e_hb, e_vb, e_fs, e_rgb}) begin
        errors++;
        $display("FAIL scan_p%0d edge %0d: got rdy/hs/vs/hb/vb/fs=%b%b%b%b%b%b rgb=%h, expected %b%b%b%b%b%b rgb=%h",
                 pc, e, s_rdy, hsync, vsync, hblank, vblank, frame_start, rgb, e_rdy, e_hs, e_vs, e_hb, e_vb, e_fs, e_rgb);
      end
    end
    checks++;
    if (pops != exp_pops) begin
      errors++;
      $display("FAIL scan_p%0d_pops: got %0d expected %0d", pc, pops, exp_pops);
    end
    checks++;
    if (fs2 - fs1 != 32 * p) begin
      errors++;
      $display("FAIL scan_p%0d_frame_period: got %0d expected %0d", pc, fs2 - fs1, 32 * p);
    end
  endtask
  task automatic test_underflow();
    do_reset();
    en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      pix_valid = !(e == 4 || e == 11);
      clr_underflow = e == 7 || e == 11;
      tick_cycle();
      if (e == 3) begin
        checks++;
        if (rgb !== 24'h010203) begin
          errors++;
          $display("FAIL uf_first_pixel: got %h expected 010203", rgb);
        end
      end
      if (e == 4) begin
        checks++;
        if ({s_rdy, underflow} !== 2'b11 || rgb !== 24'h0) begin
          errors++;
          $display("FAIL uf_missed: got rdy/uf=%b%b rgb=%h expected 11 rgb=000000", s_rdy, underflow, rgb);
        end
      end
      if (e == 5) begin
        checks++;
        if (rgb !== 24'h010204 || underflow !== 1'b1) begin
          errors++;
          $display("FAIL uf_next_word: got rgb=%h uf=%b expected rgb=010204 uf=1", rgb, underflow);
        end
      end
      if (e == 7) begin
        checks++;
        if (underflow !== 1'b0) begin
          errors++;
          $display("FAIL uf_clear: got %b expected 0", underflow);
        end
      end
      if (e == 11) begin
        checks++;
        if (underflow !== 1'b1 || rgb !== 24'h0) begin
          errors++;
          $display("FAIL uf_set_beats_clr: got uf=%b rgb=%h expected uf=1 rgb=000000", underflow, rgb);
        end
      end
    end
    pix_valid = 1'b1;
    clr_underflow = 1'b0;
  endtask
  task automatic test_reset_mid();
    reset = 1'b1;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pop: got pix_ready=%b expected 0", pix_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({hsync, vsync, hblank, vblank, frame_start, underflow} !== 6'b001100 || rgb !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_state: got hs/vs/hb/vb/fs/uf=%b rgb=%h expected 001100 rgb=000000", {hsync, vsync, hblank, vblank, frame_start, underflow}, rgb);
    end
    reset = 1'b0;
  endtask
  task automatic test_en_drop();
    int pa, pi, pb, fb;
    do_reset();
    pa = 0; pi = 0; pb = 0; fb = -1;
    for (int e = 1; e <= 106; e++) begin
      en = e < 5 || e >= 41;
      if (e == 6) begin
        pcnt = 6'd1;
        hsize = 13'd2;
      end
      tick_cycle();
      if (s_rdy) begin
        if (e <= 34) pa++;
        else if (e <= 40) pi++;
        else begin
          pb++;
          if (fb < 0) fb = e;
        end
      end
      if (e == 40) begin
        checks++;
        if ({hsync, vsync, hblank, vblank} !== 4'b0011 || rgb !== 24'h0) begin
          errors++;
          $display("FAIL drop_idle_outputs: got hs/vs/hb/vb=%b rgb=%h expected 0011 rgb=000000", {hsync, vsync, hblank, vblank}, rgb);
        end
      end
    end
    checks++;
    if (pa != 8) begin
      errors++;
      $display("FAIL drop_finish_pops: got %0d expected 8", pa);
    end
    checks++;
    if (pi != 0) begin
      errors++;
      $display("FAIL drop_idle_pops: got %0d expected 0", pi);
    end
    checks++;
    if (pb != 4) begin
      errors++;
      $display("FAIL drop_new_cfg_pops: got %0d expected 4", pb);
    end
    checks++;
    if (fb != 44) begin
      errors++;
      $display("FAIL drop_new_cfg_first_pop: got edge %0d expected 44", fb);
    end
  endtask
  task automatic test_wide();
    int p, c1, c3, low;
    logic r;
    p = 0; c1 = -1; c3 = -1; low = 0;
    pix_data2 = 40'h80_1234_5679;
    pix_valid2 = 1'b1;
    en2 = 1'b1;
    for (int c = 1; c <= 70000 && p < 3; c++) begin
      @(negedge clk);
      r = pix_ready2;
      if (hsync2 === 1'b0) low++;
      @(posedge clk);
      #1;
      if (r) begin
        p++;
        if (p == 1) begin
          c1 = c;
          checks++;
          if (rgb2 !== 40'h80_1234_5679) begin
            errors++;
            $display("FAIL wide_data_first: got %h expected 8012345679", rgb2);
          end
          pix_data2 = 40'h7F_EDCB_A986;
        end else if (p == 3) begin
          c3 = c;
          checks++;
          if (rgb2 !== 40'h7F_EDCB_A986) begin
            errors++;
            $display("FAIL wide_data_after_wrap: got %h expected 7fedcba986", rgb2);
          end
        end
      end
    end
    checks++;
    if (p != 3) begin
      errors++;
      $display("FAIL wide_pops: got %0d expected 3 within cycle budget", p);
    end
    checks++;
    if (c3 - c1 != 65536) begin
      errors++;
      $display("FAIL wide_hwrap_period: got %0d expected 65536", c3 - c1);
    end
    checks++;
    if (low != 1) begin
      errors++;
      $display("FAIL wide_hsync_active_low: got %0d low cycles expected 1", low);
    end
    en2 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_scan(0, 66, 16);
    test_scan(2, 101, 9);
    test_underflow();
    test_reset_mid();
    test_en_drop();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_pixel_engine.md
# vid_pixel_engine

Parametrised video timing and pixel output engine for the display path. It generalises the single-mode controller with configurable counter width, channel count and bits per channel, a programmable pixel-clock divider and sync polarity. It pops pixels from an upstream pixel FIFO through a valid/ready handshake and reports underflow. It sits between the register/fetch front end and the display pins.

## Interface
- CW, 13: width of all horizontal/vertical position and limit fields
- NCH, 3: colour channels per pixel
- BPC, 8: bits per channel
- PDW, 6: pixel divider width
- HS_POL, 1: active level of hsync (1 = active high)
- VS_POL, 1: active level of vsync
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- en  in  1  engine enable, level
- pcnt  in  PDW  pixel period minus one, in clk cycles
- hsize, hend, hsync_start, hsync_end  in  CW each  displayed pixels, last pixel index, sync start, sync end
- vsize, vend, vsync_start, vsync_end  in  CW each  line equivalents
- pix_valid  in  1  FIFO has a pixel
- pix_data  in  NCH*BPC  pixel; channel 0 in the LSBs
- pix_ready  out  1  pop strobe; one pixel consumed when pix_valid & pix_ready
- hsync, hblank, vsync, vblank  out  1 each  timing outputs
- rgb  out  NCH*BPC  pixel output
- frame_start  out  1  one-cycle pulse at (hcnt,vcnt)=(0,0) pixel tick
- underflow  out  1  sticky: display pixel needed with pix_valid low
- clr_underflow  in  1  clears underflow

## Operation
- Shadow registers capture all config inputs on the cycle IDLE→PRIME. Changes while running are ignored until the next start.
- FSM states:
  - IDLE: counters 0, outputs inactive, pix_ready 0. Goes to PRIME when en=1.
  - PRIME: wait for pix_valid=1, then go to RUN with hcnt=vcnt=0 and the divider cleared. If en drops, return to IDLE.
  - RUN: normal scan. If en=0 is seen, go to FINISH.
  - FINISH: identical to RUN. Go to IDLE on the tick that wraps vcnt from vend to 0.
- Divider: dcnt counts 0..pcnt. tick=1 when dcnt==pcnt. pcnt=0 gives a tick every cycle.
- Counters advance only on tick. hcnt counts 0..hend inclusive, then wraps to 0 and increments vcnt. vcnt counts 0..vend, then wraps.
- All comparisons are unsigned CW-bit. hend/vend = all-ones are legal (no overflow past limit).
- Display area: hcnt<hsize && vcnt<vsize.
  - hblank = hcnt>=hsize. vblank = vcnt>=vsize.
  - hsync active when hsync_start<=hcnt<hsync_end. If start>=end, sync is never active. vsync is the same rule on vcnt.
- Pop rule: pix_ready = tick & display area & state∈{RUN,FINISH}. pix_ready is combinational from registered state.
  - If pix_valid=1, rgb<=pix_data.
  - If pix_valid=0, rgb<=0, underflow<=1, and the pixel slot is still consumed (the counters do not stall).
- Outside the display area, rgb<=0 on tick.
- underflow: a set in the same cycle as clr_underflow wins. underflow holds across frames and across en toggles. Only reset or clr clears it.
- hsize=0 or vsize=0: no pops; the engine runs a permanently blanked frame.

## Timing
- Reset values:
  - state IDLE; counters 0; rgb 0; frame_start 0; underflow 0; pix_ready 0.
  - hblank=1, vblank=1.
  - hsync = ~HS_POL, vsync = ~VS_POL.
- hsync/hblank/vsync/vblank/rgb are registered. They update on the clk edge ending a tick cycle and reflect the counter values present during that tick. This is 1 cycle of latency from the counters.
- frame_start is registered and asserted for exactly one cycle, coincident with the first display pixel's rgb update.
- PRIME→RUN takes 1 cycle after pix_valid is seen. The first tick occurs pcnt+1 cycles into RUN.
- Reset mid-frame returns to the reset values on the next edge. No pixel is popped in the reset cycle.
- en dropping in PRIME returns to IDLE in 1 cycle. en re-asserted during FINISH is ignored until IDLE is reached.

## Structure
- Package vid_pkg holds:
  - the FSM state enum (IDLE, PRIME, RUN, FINISH)
  - the packed timing-config struct, parametrised by CW through typedef in the package with a default of 13
  - sync polarity constants
- One sub-module, vid_axis_cnt, instantiated twice (horizontal, vertical). Its ports are: advance, limit, size, sync_start, sync_end. It outputs: count, wrap, blank, sync.

## Test plan
- Reset mid-RUN: at reset, hsync=0, vsync=0, hblank=1, rgb=0, underflow=0, and no pop occurs in the reset cycle.
- pcnt=0, hsize=4, hend=7, hsync 5..6, vsize=2, vend=3, FIFO always valid with 0x010203 incrementing:
  - exactly 8 pops per frame; rgb matches the order.
  - hsync high for 2 ticks per line at hcnt 5 and 6 (output 1 cycle later).
  - frame_start once every 32 cycles.
- pcnt=2 with the same geometry: ticks every 3 cycles, the frame lasts 96 cycles, and pix_ready is high only on tick cycles.
- Drop pix_valid for one display pixel: rgb=0 for that pixel, underflow=1 and sticky. The next pixel uses the next FIFO word. clr_underflow together with another underflow leaves underflow=1.
- Deassert en at hcnt=2, vcnt=0: the engine finishes the frame (remaining pops), then goes IDLE and pix_ready stays 0. Config inputs changed meanwhile take effect only after the next PRIME.
- NCH=4, BPC=10, CW=16, HS_POL=0, hend=16'hFFFF: 40-bit data passes intact, hsync is active low, and hcnt wraps cleanly at 65535→0.
